// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the requesters/UART transmitter (master side)
// and the transmit scheduler (slave side).
interface uart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    localparam int unsigned GID_W  = $clog2(NUM_REQ);
    localparam int unsigned BYTE_W = 8;

    logic [NUM_REQ-1:0]        req;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      tx_en;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_done;
    logic                      busy;
    logic [GID_W-1:0]          grant_id;
    logic                      timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  ack, tx_en, tx_data, busy, grant_id, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output ack, tx_en, tx_data, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler handing one byte at a time from NUM_REQ requesters to a
// UART transmitter, with a watchdog that aborts a frame whose tx_done never comes.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic           clk_50M,
    input  logic           rst,
    uart_tx_sched_if.slave bus
);
    localparam int unsigned GID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = 13;
    localparam int unsigned BYTE_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GID_W-1:0] GID_RST  = GID_W'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e              r_state;
    logic [GID_W-1:0]    r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_tx_en;
    logic [NUM_REQ-1:0]  r_ack;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_busy;
    logic [GID_W-1:0]    r_grant_id;
    logic                r_timeout_err;

    state_e              w_state_nxt;
    logic [GID_W-1:0]    w_last_grant_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_tx_en_nxt;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic [BYTE_W-1:0]   w_tx_data_nxt;
    logic                w_busy_nxt;
    logic [GID_W-1:0]    w_grant_id_nxt;
    logic                w_timeout_err_nxt;

    logic                w_found;
    logic [GID_W-1:0]    w_winner;
    logic [GID_W-1:0]    w_idx;

    // Round-robin search starting just after the previous winner, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_idx    = r_last_grant;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = r_last_grant + GID_W'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        w_cnt_nxt         = r_cnt;
        w_tx_en_nxt       = 1'b0;
        w_ack_nxt         = '0;
        w_tx_data_nxt     = r_tx_data;
        w_busy_nxt        = r_busy;
        w_grant_id_nxt    = r_grant_id;
        w_timeout_err_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt         = S_BUSY;
                    w_last_grant_nxt    = w_winner;
                    w_cnt_nxt           = '0;
                    w_tx_en_nxt         = 1'b1;
                    w_ack_nxt[w_winner] = 1'b1;
                    w_tx_data_nxt       = bus.req_data[{w_winner, 3'b000} +: BYTE_W];
                    w_busy_nxt          = 1'b1;
                    w_grant_id_nxt      = w_winner;
                end
            end
            S_BUSY: begin
                // tx_done outranks a watchdog expiry landing in the same cycle.
                if (bus.tx_done) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt       = S_IDLE;
                    w_busy_nxt        = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; last_grant resets to the top index so requester 0 wins first.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= GID_RST;
            r_cnt         <= '0;
            r_tx_en       <= 1'b0;
            r_ack         <= '0;
            r_tx_data     <= '0;
            r_busy        <= 1'b0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_cnt         <= w_cnt_nxt;
            r_tx_en       <= w_tx_en_nxt;
            r_ack         <= w_ack_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_busy        <= w_busy_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.tx_en       = r_tx_en;
    assign bus.ack         = r_ack;
    assign bus.tx_data     = r_tx_data;
    assign bus.busy        = r_busy;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed plus randomized bench for uart_tx_sched against a transaction-level
// round-robin model of the scheduler.
module tb_uart_tx_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TO   = 5000;

    logic clk_50M = 1'b0;
    logic rst;

    uart_tx_sched_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_sched #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .bus     (bus)
    );

    always #10 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_errors = 0;
    int m_last;

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first set request scanning upward from last+1, modulo 4.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One complete ownership: request in IDLE, grant, then end by tx_done at
    // cycle done_at after tx_en (done_at < 0 means never -> watchdog expiry).
    task automatic frame(input logic [3:0] r, input logic [31:0] d,
                         input int done_at, input bit wiggle);
        int          w;
        logic [7:0]  b;
        bus.req      = r;
        bus.req_data = d;
        bus.tx_done  = 1'b0;
        tick();
        w      = rr_pick(r, m_last);
        m_last = w;
        b      = d[8*w +: 8];
        chk("start_tx_en",   32'(bus.tx_en),       32'd1);
        chk("start_ack",     32'(bus.ack),         32'd1 << w);
        chk("start_tx_data", 32'(bus.tx_data),     32'(b));
        chk("start_grant",   32'(bus.grant_id),    32'(w));
        chk("start_busy",    32'(bus.busy),        32'd1);
        chk("start_tmo",     32'(bus.timeout_err), 32'd0);
        for (int c = 1; c <= int'(TO); c++) begin
            if (c - 1 == done_at) bus.tx_done = 1'b1;
            if (wiggle) begin
                bus.req      = 4'($urandom);
                bus.req_data = $urandom;
            end
            tick();
            bus.tx_done = 1'b0;
            if (c - 1 == done_at) begin
                chk("done_busy",  32'(bus.busy),        32'd0);
                chk("done_tmo",   32'(bus.timeout_err), 32'd0);
                chk("done_tx_en", 32'(bus.tx_en),       32'd0);
                chk("done_grant", 32'(bus.grant_id),    32'(w));
                return;
            end
            if (c == int'(TO)) begin
                chk("tmo_pulse", 32'(bus.timeout_err), 32'd1);
                chk("tmo_busy",  32'(bus.busy),        32'd0);
                chk("tmo_grant", 32'(bus.grant_id),    32'(w));
                bus.req = 4'b0000;
                tick();
                chk("tmo_once",      32'(bus.timeout_err), 32'd0);
                chk("tmo_idle_busy", 32'(bus.busy),        32'd0);
                return;
            end
            chk("hold_busy",    32'(bus.busy),        32'd1);
            chk("hold_tx_en",   32'(bus.tx_en),       32'd0);
            chk("hold_ack",     32'(bus.ack),         32'd0);
            chk("hold_tmo",     32'(bus.timeout_err), 32'd0);
            chk("hold_tx_data", 32'(bus.tx_data),     32'(b));
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = 4'b0000;
        bus.req_data = 32'h0;
        bus.tx_done  = 1'b0;
        m_last       = 3;
        tick();
        tick();
        chk("rst_busy",    32'(bus.busy),        32'd0);
        chk("rst_tx_en",   32'(bus.tx_en),       32'd0);
        chk("rst_ack",     32'(bus.ack),         32'd0);
        chk("rst_tx_data", 32'(bus.tx_data),     32'd0);
        chk("rst_grant",   32'(bus.grant_id),    32'd0);
        chk("rst_tmo",     32'(bus.timeout_err), 32'd0);

        // Reset dominates pending requests.
        bus.req = 4'hF;
        tick();
        chk("rst_prio_busy",  32'(bus.busy),  32'd0);
        chk("rst_prio_tx_en", 32'(bus.tx_en), 32'd0);

        rst     = 1'b0;
        bus.req = 4'b0000;
        tick();
        chk("idle_noreq_busy", 32'(bus.busy), 32'd0);

        // Stray tx_done while idle is ignored.
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("idle_done_busy",  32'(bus.busy),     32'd0);
        chk("idle_done_grant", 32'(bus.grant_id), 32'd0);
        chk("idle_done_tx_en", 32'(bus.tx_en),    32'd0);

        // Single full-length frame from requester 0.
        frame(4'b0001, 32'h0000_0055, 4349, 1'b0);

        // Everyone requesting continuously: grants rotate.
        repeat (5) frame(4'hF, $urandom, int'($urandom_range(20, 0)), 1'b0);

        // Owner's data and all requests churn mid-frame.
        frame(4'b0010, $urandom, 25, 1'b1);

        // Watchdog expiry, then normal service resumes.
        frame(4'($urandom_range(15, 1)), $urandom, -1, 1'b0);
        frame(4'($urandom_range(15, 1)), $urandom, 3, 1'b0);

        // tx_done on the last counted cycle beats the watchdog.
        frame(4'($urandom_range(15, 1)), $urandom, int'(TO) - 1, 1'b0);

        repeat (20) frame(4'($urandom_range(15, 1)), $urandom,
                          int'($urandom_range(40, 0)), 1'b1);

        // Reset in the middle of a frame owned by requester 2.
        bus.req      = 4'b0100;
        bus.req_data = 32'hA1B2_C3D4;
        tick();
        chk("rbusy_grant", 32'(bus.grant_id), 32'd2);
        chk("rbusy_busy",  32'(bus.busy),     32'd1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rbusy_rst_busy",  32'(bus.busy),        32'd0);
        chk("rbusy_rst_tx_en", 32'(bus.tx_en),       32'd0);
        chk("rbusy_rst_ack",   32'(bus.ack),         32'd0);
        chk("rbusy_rst_tmo",   32'(bus.timeout_err), 32'd0);
        chk("rbusy_rst_grant", 32'(bus.grant_id),    32'd0);
        rst    = 1'b0;
        m_last = 3;
        // With last_grant back at 3, 4'b1100 must go to requester 2, not 3.
        frame(4'b1100, $urandom, 4, 1'b0);
        frame(4'b1100, $urandom, 4, 1'b0);
        frame(4'b0100, $urandom, 2, 1'b0);

        bus.req = 4'b0000;
        repeat (3) tick();
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters (fixed at 4 for this revision).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 5000: maximum BUSY cycles allowed before tx_done (one frame is 10 bits x 435 cycles = 4350).
REQ-003 The block SHALL have port clk_50M  input  1  system 50 MHz clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous to clk_50M and active-high.
REQ-005 The block SHALL have port req  input  4  per-requester send request; bit i belongs to requester i.
REQ-006 The block SHALL have port req_data  input  32  request bytes; requester i's byte is bits [8i+7:8i].
REQ-007 The block SHALL have port ack  output  4  one-cycle pulse; the byte of requester i has been accepted.
REQ-008 The block SHALL have port tx_en  output  1  start pulse to the UART transmitter.
REQ-009 The block SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-010 The block SHALL have port tx_done  input  1  one-cycle completion pulse from the UART transmitter.
REQ-011 The block SHALL have port busy  output  1  high while a frame is owned.
REQ-012 The block SHALL have port grant_id  output  2  index of the current or most recent owner.
REQ-013 The block SHALL have port timeout_err  output  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-014 The block SHALL implement the two-state FSM IDLE/BUSY, and all outputs SHALL be registered.
REQ-015 In IDLE with req != 0, the block SHALL select a winner by round-robin and go to BUSY on the next edge; with req == 0 it SHALL stay in IDLE.
REQ-016 Round-robin SHALL search from (last_grant+1) mod 4 upward with wrap-around, and last_grant SHALL update to the winner.
REQ-017 On the IDLE->BUSY edge the block SHALL load tx_data with the winner's byte, set tx_en=1, set ack[winner]=1 (one bit only), set grant_id=winner and set busy=1.
REQ-018 tx_en and ack SHALL be high for exactly one cycle and SHALL return to 0 on the following edge.
REQ-019 tx_data SHALL stay stable from load until the block returns to IDLE, whatever req_data does.
REQ-020 A requester SHALL deassert req the cycle after ack or it re-enters arbitration; the block SHALL ignore req and req_data throughout BUSY.
REQ-021 In BUSY, tx_done=1 SHALL return the block to IDLE and clear busy on the next edge; arbitration SHALL be possible in the first IDLE cycle, so the next tx_en occurs 2 cycles after tx_done.
REQ-022 tx_done seen in IDLE SHALL be ignored, with no state change.
REQ-023 A BUSY cycle counter of 13 bits SHALL reset to 0 on BUSY entry and increment each BUSY cycle.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 without tx_done, the block SHALL pulse timeout_err for one cycle, go to IDLE and clear busy.
REQ-025 If tx_done and the timeout occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay 0.
REQ-026 grant_id SHALL hold its value in IDLE.

Reset
REQ-027 With rst=1 at a clock edge, the block SHALL go to IDLE and clear tx_en, ack, busy, timeout_err, tx_data, grant_id and the counter to 0, and set last_grant=3 so requester 0 has first priority.
REQ-028 rst SHALL take priority over all other inputs; reset during BUSY SHALL abandon the frame with no ack, tx_en or timeout_err pulse.

Verification
REQ-029 Reset, then req=4'b0001 with byte 0x55 -> next cycle tx_en=1, ack=4'b0001, tx_data=0x55, grant_id=0, busy=1; tx_done after 4350 cycles -> busy=0 one cycle later.
REQ-030 req=4'b1111 held continuously with tx_done returned for each frame -> grant order 0,1,2,3,0; tx_en and ack are each single-cycle pulses.
REQ-031 Change req_data for the owner mid-frame -> tx_data unchanged until IDLE.
REQ-032 No tx_done after grant -> timeout_err pulses exactly once, TIMEOUT_CYCLES cycles after tx_en; busy=0; next request is granted normally.
REQ-033 tx_done on the final timeout cycle -> timeout_err=0 and normal return to IDLE.
REQ-034 Assert rst while BUSY with req=4'b0100 -> busy=0 and tx_en=0 next cycle; after release the first grant goes to requester 2 and last_grant is reset.
